// File: rtl/sdram_user_pkg.sv
// Shared definitions for the SDRAM user-port responder: state encoding and
// default widths/latencies also used by the controller wrapper.
package sdram_user_pkg;

  localparam int ADDR_WIDTH_DEF = 25;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int WR_CYCLES_DEF  = 3;
  localparam int RD_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

endpackage

// File: rtl/sdram_user_mem.sv
// Single-port synchronous RAM with registered read, written so that it maps
// onto block RAM. Read data appears the cycle after the address is presented.
module sdram_user_mem #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdram_user_responder.sv
// Block-RAM-backed stand-in for the SDRAM controller user port (ack/busy/rd_ready
// responder). Define SDRAM_USER_RESPONDER_REFRESH_EN to add periodic refresh windows.
module sdram_user_responder
  import sdram_user_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WR_CYCLES      = WR_CYCLES_DEF,
`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8,
`endif
  parameter int RD_LATENCY     = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  output logic                  busy,
  output logic                  ack
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_READY_AT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_LATENCY);

  state_t                    r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic [MEM_ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic                      r_ack, w_ack_next;
  logic                      r_busy, w_busy_next;
  logic                      r_rd_ready, w_rd_ready_next;
  logic [DATA_WIDTH-1:0]     r_rd_data, w_rd_data_next;
  logic                      w_mem_we;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]     w_mem_rdata;
  logic                      w_ref_due;
  logic                      w_unused_addr_hi;

  // Upper address bits alias onto the same RAM location by design.
  assign w_unused_addr_hi = ^{wr_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                              rd_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_PERIOD);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [REF_W-1:0] r_ref_cnt;
  logic             r_ref_pending;
  logic             w_ref_wrap;

  assign w_ref_wrap = (r_ref_cnt == REF_W'(REFRESH_PERIOD - 1));
  assign w_ref_due  = w_ref_wrap | r_ref_pending;

  // A wrap seen outside IDLE is remembered; IDLE always consumes a due refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
      if (r_state == ST_IDLE) begin
        r_ref_pending <= 1'b0;
      end else if (w_ref_wrap) begin
        r_ref_pending <= 1'b1;
      end
    end
  end
`else
  assign w_ref_due = 1'b0;
`endif

  // The RAM address is steered from the request port while IDLE so the
  // registered read is already under way in the ack cycle.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt + 1'b1;
    w_addr_next     = r_addr;
    w_ack_next      = 1'b0;
    w_busy_next     = r_busy;
    w_rd_ready_next = 1'b0;
    w_rd_data_next  = r_rd_data;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_addr;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next  = '0;
        w_busy_next = 1'b0;
        if (w_ref_due) begin
          w_state_next = ST_REFRESH;
          w_busy_next  = 1'b1;
        end else if (wr_enable) begin
          w_mem_we     = !rst;
          w_mem_addr   = wr_addr[MEM_ADDR_WIDTH-1:0];
          w_addr_next  = wr_addr[MEM_ADDR_WIDTH-1:0];
          w_state_next = ST_WRITE;
          w_ack_next   = 1'b1;
          w_busy_next  = 1'b1;
        end else if (rd_enable) begin
          w_mem_addr   = rd_addr[MEM_ADDR_WIDTH-1:0];
          w_addr_next  = rd_addr[MEM_ADDR_WIDTH-1:0];
          w_state_next = ST_READ;
          w_ack_next   = 1'b1;
          w_busy_next  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_cnt == WR_LAST) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      end
      ST_READ: begin
        if (r_cnt == RD_READY_AT) begin
          w_rd_ready_next = 1'b1;
          w_rd_data_next  = w_mem_rdata;
        end
        if (r_cnt == RD_LAST) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      end
`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
      ST_REFRESH: begin
        if (r_cnt == REF_LAST) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_ready <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_addr     <= w_addr_next;
      r_ack      <= w_ack_next;
      r_busy     <= w_busy_next;
      r_rd_ready <= w_rd_ready_next;
      r_rd_data  <= w_rd_data_next;
    end
  end

  sdram_user_mem #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (wr_data),
    .o_rdata (w_mem_rdata)
  );

  assign rd_data  = r_rd_data;
  assign rd_ready = r_rd_ready;
  assign busy     = r_busy;
  assign ack      = r_ack;

endmodule

// File: tb/tb_sdram_user_responder.sv
// Directed bench for sdram_user_responder; inputs change and outputs are
// sampled just after the falling edge.
module tb_sdram_user_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] wr_addr;
  logic        wr_enable;
  logic [7:0]  wr_data;
  logic [24:0] rd_addr;
  logic        rd_enable;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        busy;
  logic        ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_user_responder #(
`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
    .REFRESH_PERIOD (20),
    .REFRESH_CYCLES (8),
`endif
    .MEM_ADDR_WIDTH (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_addr   (wr_addr),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_enable (rd_enable),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .ack       (ack)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Issue a write at a falling edge; returns ack latency and busy length.
  task automatic do_write(input logic [24:0] a, input logic [7:0] d,
                          output int ack_lat, output int busy_len);
    wr_addr   = a;
    wr_data   = d;
    wr_enable = 1'b1;
    ack_lat   = -1;
    busy_len  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack) begin
        ack_lat = k;
        break;
      end
    end
    wr_enable = 1'b0;
    if (ack_lat > 0) begin
      while (busy && busy_len < 40) begin
        busy_len++;
        @(negedge clk);
      end
    end
    $display("write addr=%07h data=%02h ack_lat=%0d busy=%0d", a, d, ack_lat, busy_len);
  endtask

  // Issue a read; rdy_lat counts cycles from the ack cycle to the rd_ready cycle.
  task automatic do_read(input logic [24:0] a, output int ack_lat, output int rdy_lat,
                         output int rdy_cnt, output logic [7:0] data, output int busy_len);
    rd_addr   = a;
    rd_enable = 1'b1;
    ack_lat   = -1;
    rdy_lat   = -1;
    rdy_cnt   = 0;
    data      = 8'hxx;
    busy_len  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack) begin
        ack_lat = k;
        break;
      end
    end
    rd_enable = 1'b0;
    if (ack_lat > 0) begin
      while (busy && busy_len < 40) begin
        if (rd_ready) begin
          rdy_cnt++;
          if (rdy_lat < 0) begin
            rdy_lat = busy_len;
            data    = rd_data;
          end
        end
        busy_len++;
        @(negedge clk);
      end
    end
    $display("read  addr=%07h data=%02h ack_lat=%0d rdy_lat=%0d busy=%0d", a, data, ack_lat, rdy_lat, busy_len);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready: got %b expected 0", rd_ready); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %02h expected 00", rd_data); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_write_read();
    int al, bl, rl, rc;
    logic [7:0] d;
    do_write(25'h0000012, 8'hA5, al, bl);
    total++; if (al !== 1) begin bad++; $display("FAIL wr_ack_lat: got %0d expected 1", al); end
    total++; if (bl !== 3) begin bad++; $display("FAIL wr_busy_len: got %0d expected 3", bl); end
    do_read(25'h0000012, al, rl, rc, d, bl);
    total++; if (al !== 1) begin bad++; $display("FAIL rd_ack_lat: got %0d expected 1", al); end
    total++; if (rl !== 4) begin bad++; $display("FAIL rd_ready_lat: got %0d expected 4", rl); end
    total++; if (rc !== 1) begin bad++; $display("FAIL rd_ready_count: got %0d expected 1", rc); end
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL rd_data: got %02h expected a5", d); end
    total++; if (bl !== 5) begin bad++; $display("FAIL rd_busy_len: got %0d expected 5", bl); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL rd_data_hold: got %02h expected a5", rd_data); end
  endtask

  task automatic test_simultaneous();
    int k, n, acks, m;
    wr_addr = 25'h3; wr_data = 8'h5C; rd_addr = 25'h3;
    wr_enable = 1'b1; rd_enable = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 20);
    wr_enable = 1'b0;
    total++; if (k !== 1) begin bad++; $display("FAIL sim_wr_ack_lat: got %0d expected 1", k); end
    n = 0; acks = 0;
    while (busy && n < 40) begin
      if (ack) acks++;
      n++;
      @(negedge clk);
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL sim_acks_in_write: got %0d expected 1", acks); end
    total++; if (n !== 3) begin bad++; $display("FAIL sim_wr_busy_len: got %0d expected 3", n); end
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 20);
    rd_enable = 1'b0;
    total++; if (k !== 1) begin bad++; $display("FAIL sim_rd_ack_lat: got %0d expected 1", k); end
    m = 0;
    while (!rd_ready && m < 20) begin m++; @(negedge clk); end
    total++; if (m !== 4) begin bad++; $display("FAIL sim_rd_ready_lat: got %0d expected 4", m); end
    total++; if (rd_data !== 8'h5C) begin bad++; $display("FAIL sim_rd_data: got %02h expected 5c", rd_data); end
    while (busy && m < 40) begin m++; @(negedge clk); end
    $display("simultaneous wr/rd addr=3 data=%02h", rd_data);
  endtask

  task automatic test_aliasing();
    int al, bl, rl, rc;
    logic [7:0] d;
    do_write(25'h0000401, 8'h11, al, bl);
    do_write(25'h0000002, 8'h22, al, bl);
    do_read(25'h0000001, al, rl, rc, d, bl);
    total++; if (d !== 8'h11) begin bad++; $display("FAIL alias_low: got %02h expected 11", d); end
    do_read(25'h1FFFC02, al, rl, rc, d, bl);
    total++; if (d !== 8'h22) begin bad++; $display("FAIL alias_high: got %02h expected 22", d); end
  endtask

  task automatic test_busy_blocking();
    int k, n, acks, rdys;
    wr_addr = 25'h20; wr_data = 8'h77; wr_enable = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 20);
    wr_enable = 1'b0;
    rd_addr = 25'h20; rd_enable = 1'b1;
    n = 0; acks = 0;
    while (busy && n < 40) begin
      if (ack) acks++;
      n++;
      @(negedge clk);
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL block_acks_in_busy: got %0d expected 1", acks); end
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 20);
    rd_enable = 1'b0;
    total++; if (k !== 1) begin bad++; $display("FAIL block_rd_ack_lat: got %0d expected 1", k); end
    acks = 0; rdys = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (rd_ready) rdys++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL block_extra_acks: got %0d expected 0", acks); end
    total++; if (rdys !== 1) begin bad++; $display("FAIL block_reads: got %0d expected 1", rdys); end
    total++; if (rd_data !== 8'h77) begin bad++; $display("FAIL block_rd_data: got %02h expected 77", rd_data); end
    $display("busy-blocking read addr=20 data=%02h", rd_data);
  endtask

  task automatic test_reset_mid_read();
    int al, bl, rl, rc, rdys;
    logic [7:0] d;
    do_write(25'h55, 8'h3C, al, bl);
    rd_addr = 25'h55; rd_enable = 1'b1;
    @(negedge clk);
    rd_enable = 1'b0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL rst_mid_ack: got %b expected 1", ack); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rd_data: got %02h expected 00", rd_data); end
    rdys = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_ready) rdys++;
      @(negedge clk);
    end
    total++; if (rdys !== 0) begin bad++; $display("FAIL rst_mid_rd_ready: got %0d expected 0", rdys); end
    do_read(25'h55, al, rl, rc, d, bl);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL rst_mid_readback: got %02h expected 3c", d); end
  endtask

  task automatic test_reset_priority();
    int al, bl, rl, rc;
    logic [7:0] d;
    do_write(25'h77, 8'h12, al, bl);
    wr_addr = 25'h77; wr_data = 8'h99; wr_enable = 1'b1; rst = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0; rst = 1'b0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_prio_ack: got %b expected 0", ack); end
    @(negedge clk);
    do_read(25'h77, al, rl, rc, d, bl);
    total++; if (d !== 8'h12) begin bad++; $display("FAIL rst_prio_data: got %02h expected 12", d); end
  endtask

`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
  task automatic test_refresh();
    int run, last, rises, period_bad, len_bad, acks, k;
    logic prev;
    run = 0; last = -1; rises = 0; period_bad = 0; len_bad = 0; acks = 0; prev = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (busy) begin
        run++;
      end else begin
        if (run > 0 && run != 8) len_bad++;
        run = 0;
      end
      if (busy && !prev) begin
        if (last >= 0 && (i - last) != 20) period_bad++;
        last = i;
        rises++;
      end
      prev = busy;
    end
    $display("refresh idle run rises=%0d", rises);
    total++; if (rises < 3) begin bad++; $display("FAIL ref_windows: got %0d expected >=3", rises); end
    total++; if (len_bad !== 0) begin bad++; $display("FAIL ref_length: got %0d bad windows expected 0", len_bad); end
    total++; if (period_bad !== 0) begin bad++; $display("FAIL ref_period: got %0d bad gaps expected 0", period_bad); end
    total++; if (acks !== 0) begin bad++; $display("FAIL ref_ack: got %0d acks expected 0", acks); end
    k = 0;
    while (busy && k < 40) begin k++; @(negedge clk); end
    k = 0;
    while (!busy && k < 40) begin k++; @(negedge clk); end
    rd_addr = 25'h5; rd_enable = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 30);
    rd_enable = 1'b0;
    total++; if (k !== 9) begin bad++; $display("FAIL ref_rd_ack_lat: got %0d expected 9", k); end
    k = 0;
    while (busy && k < 40) begin k++; @(negedge clk); end
    $display("read during refresh acked");
  endtask
`endif

  initial begin
    test_reset();
`ifdef SDRAM_USER_RESPONDER_REFRESH_EN
    test_refresh();
`else
    test_write_read();
    test_simultaneous();
    test_aliasing();
    test_busy_blocking();
    test_reset_mid_read();
    test_reset_priority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
